// File: rtl/wb_retire_stage.sv
// In-order retire queue between the memory-access stage and the register-file write port.
// Retires the head entry when the write port grants; supports cancel (flush) and backpressure.
module wb_retire_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned WSTRB_W = DATA_W / 8,
    localparam int unsigned BUS_W   = WSTRB_W + ADDR_W + DATA_W + PC_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ma_validout,
    input  logic [BUS_W-1:0]              ma_to_wb_bus,
    output logic                          wb_allowin,
    input  logic                          rf_ready,
    input  logic                          wb_cancel,
    output logic                          wb_validout,
    output logic [WSTRB_W+ADDR_W+DATA_W-1:0] wb_regfile_bus,
    output logic [DEPTH*ADDR_W-1:0]       wb_dest_vec,
    output logic [PC_W-1:0]               debug_wb_pc,
    output logic [WSTRB_W-1:0]            debug_wb_rf_we,
    output logic [ADDR_W-1:0]             debug_wb_rf_wnum,
    output logic [DATA_W-1:0]             debug_wb_rf_wdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   head_q, tail_q, head_nxt, tail_nxt;
    logic [CNT_W-1:0]   count_q;
    logic               valid_q  [DEPTH];
    logic [WSTRB_W-1:0] wstrb_q  [DEPTH];
    logic [ADDR_W-1:0]  dest_q   [DEPTH];
    logic [DATA_W-1:0]  result_q [DEPTH];
    logic [PC_W-1:0]    pc_q     [DEPTH];

    logic [WSTRB_W-1:0] in_wstrb;
    logic [ADDR_W-1:0]  in_dest;
    logic [DATA_W-1:0]  in_result;
    logic [PC_W-1:0]    in_pc;
    logic               head_v, pop, push;
    logic [WSTRB_W-1:0] rf_we;

    assign in_wstrb  = ma_to_wb_bus[BUS_W-1 -: WSTRB_W];
    assign in_dest   = ma_to_wb_bus[PC_W+DATA_W +: ADDR_W];
    assign in_result = ma_to_wb_bus[PC_W +: DATA_W];
    assign in_pc     = ma_to_wb_bus[PC_W-1:0];

    // With DEPTH a power of two the pointers wrap naturally; DEPTH=1 pins them at slot 0.
    assign head_nxt = (DEPTH == 1) ? '0 : head_q + PTR_W'(1);
    assign tail_nxt = (DEPTH == 1) ? '0 : tail_q + PTR_W'(1);

    // rst is gated in so a reset cycle can never produce a write for discarded entries.
    assign head_v     = valid_q[head_q];
    assign pop        = head_v & rf_ready & ~wb_cancel & ~rst;
    assign wb_allowin = (count_q != FullCnt) | pop;
    assign push       = ma_validout & wb_allowin & ~wb_cancel & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                wstrb_q[i]  <= '0;
                dest_q[i]   <= '0;
                result_q[i] <= '0;
                pc_q[i]     <= '0;
            end
        end else if (wb_cancel) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            // Clear precedes set so a full-queue push+pop on the same slot stays valid.
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_nxt;
            end
            if (push) begin
                valid_q[tail_q]  <= 1'b1;
                wstrb_q[tail_q]  <= in_wstrb;
                dest_q[tail_q]   <= in_dest;
                result_q[tail_q] <= in_result;
                pc_q[tail_q]     <= in_pc;
                tail_q           <= tail_nxt;
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        rf_we = pop ? wstrb_q[head_q] : '0;
    end

    assign wb_validout       = pop;
    assign wb_regfile_bus    = {rf_we, dest_q[head_q], result_q[head_q]};
    assign debug_wb_pc       = pc_q[head_q];
    assign debug_wb_rf_we    = rf_we;
    assign debug_wb_rf_wnum  = dest_q[head_q];
    assign debug_wb_rf_wdata = result_q[head_q];

    always_comb begin
        wb_dest_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wb_dest_vec[i*ADDR_W +: ADDR_W] = valid_q[i] ? dest_q[i] : '0;
        end
    end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Randomised and directed bench for wb_retire_stage against a queue-based reference model.
module tb_wb_retire_stage;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int PC_W    = 32;
    localparam int DEPTH   = 2;
    localparam int WSTRB_W = DATA_W / 8;
    localparam int BUS_W   = WSTRB_W + ADDR_W + DATA_W + PC_W;

    typedef struct {
        logic [WSTRB_W-1:0] wstrb;
        logic [ADDR_W-1:0]  dest;
        logic [DATA_W-1:0]  result;
        logic [PC_W-1:0]    pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ma_validout = 1'b0;
    logic [BUS_W-1:0] ma_to_wb_bus = '0;
    logic rf_ready = 1'b0;
    logic wb_cancel = 1'b0;
    logic wb_allowin, wb_validout;
    logic [WSTRB_W+ADDR_W+DATA_W-1:0] wb_regfile_bus;
    logic [DEPTH*ADDR_W-1:0] wb_dest_vec;
    logic [PC_W-1:0] debug_wb_pc;
    logic [WSTRB_W-1:0] debug_wb_rf_we;
    logic [ADDR_W-1:0] debug_wb_rf_wnum;
    logic [DATA_W-1:0] debug_wb_rf_wdata;

    wb_retire_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ma_validout(ma_validout), .ma_to_wb_bus(ma_to_wb_bus),
        .wb_allowin(wb_allowin), .rf_ready(rf_ready), .wb_cancel(wb_cancel),
        .wb_validout(wb_validout), .wb_regfile_bus(wb_regfile_bus), .wb_dest_vec(wb_dest_vec),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: age-ordered queue plus the physical slot index of its oldest entry.
    ent_t model_q[$];
    int   model_head = 0;
    logic [ADDR_W-1:0] retire_log[$];

    always begin : compare
        logic m_pop, m_allow, m_push, m_clear;
        logic [DEPTH*ADDR_W-1:0] m_vec;
        logic [WSTRB_W-1:0] m_we;
        logic [BUS_W-1:0] m_bus;
        ent_t e;
        @(negedge clk);
        m_pop   = (model_q.size() > 0) && rf_ready && !wb_cancel && !rst;
        m_allow = (model_q.size() != DEPTH) || m_pop;
        m_push  = ma_validout && m_allow && !wb_cancel && !rst;
        m_clear = rst || wb_cancel;
        m_bus   = ma_to_wb_bus;
        m_vec   = '0;
        for (int k = 0; k < model_q.size(); k++) begin
            m_vec[((model_head + k) % DEPTH)*ADDR_W +: ADDR_W] = model_q[k].dest;
        end
        m_we = m_pop ? model_q[0].wstrb : '0;
        check("wb_allowin", 128'(wb_allowin), 128'(m_allow));
        check("wb_validout", 128'(wb_validout), 128'(m_pop));
        check("rf_we", 128'(wb_regfile_bus[WSTRB_W+ADDR_W+DATA_W-1 -: WSTRB_W]), 128'(m_we));
        check("debug_wb_rf_we", 128'(debug_wb_rf_we), 128'(m_we));
        check("wb_dest_vec", 128'(wb_dest_vec), 128'(m_vec));
        if (m_pop) begin
            check("rf_waddr", 128'(wb_regfile_bus[DATA_W +: ADDR_W]), 128'(model_q[0].dest));
            check("rf_wdata", 128'(wb_regfile_bus[DATA_W-1:0]), 128'(model_q[0].result));
            check("debug_wb_pc", 128'(debug_wb_pc), 128'(model_q[0].pc));
            check("debug_wb_rf_wnum", 128'(debug_wb_rf_wnum), 128'(model_q[0].dest));
            check("debug_wb_rf_wdata", 128'(debug_wb_rf_wdata), 128'(model_q[0].result));
        end
        if (wb_validout) retire_log.push_back(wb_regfile_bus[DATA_W +: ADDR_W]);
        @(posedge clk);
        if (m_clear) begin
            model_q.delete();
            model_head = 0;
        end else begin
            if (m_pop) begin
                void'(model_q.pop_front());
                model_head = (model_head + 1) % DEPTH;
            end
            if (m_push) begin
                e.wstrb  = m_bus[BUS_W-1 -: WSTRB_W];
                e.dest   = m_bus[PC_W+DATA_W +: ADDR_W];
                e.result = m_bus[PC_W +: DATA_W];
                e.pc     = m_bus[PC_W-1:0];
                model_q.push_back(e);
            end
        end
    end

    function automatic logic [BUS_W-1:0] mk(input logic [3:0] ws, input logic [4:0] d,
                                             input logic [31:0] r, input logic [31:0] p);
        return {ws, d, r, p};
    endfunction

    task automatic drive(input logic mv, input logic [BUS_W-1:0] b, input logic rr,
                         input logic cn, input logic rs);
        @(posedge clk);
        #1;
        ma_validout  = mv;
        ma_to_wb_bus = b;
        rf_ready     = rr;
        wb_cancel    = cn;
        rst          = rs;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".allowin"}, 128'(wb_allowin), 128'(1));
        check({tag, ".validout"}, 128'(wb_validout), 128'(0));
        check({tag, ".regfile_bus"}, 128'(wb_regfile_bus), 128'(0));
        check({tag, ".dest_vec"}, 128'(wb_dest_vec), 128'(0));
        check({tag, ".dbg_we"}, 128'(debug_wb_rf_we), 128'(0));
        check({tag, ".dbg_pc"}, 128'(debug_wb_pc), 128'(0));
        check({tag, ".dbg_wnum"}, 128'(debug_wb_rf_wnum), 128'(0));
        check({tag, ".dbg_wdata"}, 128'(debug_wb_rf_wdata), 128'(0));
    endtask

    initial begin
        logic [BUS_W-1:0] rb;
        // Reset state
        drive(0, '0, 1, 0, 1);
        drive(0, '0, 1, 0, 0);
        @(negedge clk);
        check_reset_outputs("reset");

        // Back-to-back entries, dest 3,4,5
        retire_log.delete();
        drive(1, mk(4'hF, 5'd3, 32'h11, 32'h1c000000), 1, 0, 0);
        drive(1, mk(4'hF, 5'd4, 32'h22, 32'h1c000004), 1, 0, 0);
        @(negedge clk);
        check("b2b.rf_we", 128'(wb_regfile_bus[WSTRB_W+ADDR_W+DATA_W-1 -: WSTRB_W]), 128'hF);
        check("b2b.dbg_pc", 128'(debug_wb_pc), 128'h1c000000);
        drive(1, mk(4'hF, 5'd5, 32'h33, 32'h1c000008), 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, '0, 1, 0, 0);
        @(negedge clk);
        check("b2b.count", 128'(retire_log.size()), 128'(3));
        if (retire_log.size() == 3) begin
            check("b2b.order0", 128'(retire_log[0]), 128'(3));
            check("b2b.order1", 128'(retire_log[1]), 128'(4));
            check("b2b.order2", 128'(retire_log[2]), 128'(5));
        end

        // Backpressure from pointer origin
        drive(0, '0, 0, 0, 1);
        drive(1, mk(4'hF, 5'd6, 32'h66, 32'h100), 0, 0, 0);
        drive(1, mk(4'hF, 5'd7, 32'h77, 32'h104), 0, 0, 0);
        drive(1, mk(4'hF, 5'd8, 32'h88, 32'h108), 0, 0, 0);
        @(negedge clk);
        check("bp.allowin", 128'(wb_allowin), 128'(0));
        check("bp.dest_vec", 128'(wb_dest_vec), 128'({5'd7, 5'd6}));
        drive(1, mk(4'hF, 5'd8, 32'h88, 32'h108), 1, 0, 0);
        @(negedge clk);
        check("bp.retire6", 128'(debug_wb_rf_wnum), 128'(6));
        check("bp.accept", 128'(wb_allowin), 128'(1));
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);

        // Full queue streaming with wrap
        drive(1, mk(4'hF, 5'd1, 32'h1, 32'h200), 0, 0, 0);
        drive(1, mk(4'hF, 5'd2, 32'h2, 32'h204), 0, 0, 0);
        for (int i = 0; i < 8; i++)
            drive(1, mk(4'hF, 5'(10 + i), 32'(i), 32'h208 + 32'(4 * i)), 1, 0, 0);
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);
        drive(0, '0, 1, 0, 0);

        // Cancel with two queued
        drive(1, mk(4'hF, 5'd20, 32'h20, 32'h300), 0, 0, 0);
        drive(1, mk(4'hF, 5'd21, 32'h21, 32'h304), 0, 0, 0);
        drive(0, '0, 1, 1, 0);
        @(negedge clk);
        check("cancel.validout", 128'(wb_validout), 128'(0));
        check("cancel.rf_we", 128'(debug_wb_rf_we), 128'(0));
        drive(0, '0, 1, 0, 0);
        @(negedge clk);
        check("cancel.dest_vec", 128'(wb_dest_vec), 128'(0));
        check("cancel.allowin", 128'(wb_allowin), 128'(1));
        check("cancel.noretire", 128'(wb_validout), 128'(0));

        // Partial and zero strobes
        drive(1, mk(4'h3, 5'd9, 32'hAABBCCDD, 32'h400), 1, 0, 0);
        drive(1, mk(4'h0, 5'd10, 32'h1234, 32'h404), 1, 0, 0);
        @(negedge clk);
        check("strb.rf_we", 128'(wb_regfile_bus[WSTRB_W+ADDR_W+DATA_W-1 -: WSTRB_W]), 128'h3);
        check("strb.dbg_we", 128'(debug_wb_rf_we), 128'h3);
        check("strb.wdata", 128'(debug_wb_rf_wdata), 128'hAABBCCDD);
        drive(0, '0, 1, 0, 0);
        @(negedge clk);
        check("zstrb.validout", 128'(wb_validout), 128'(1));
        check("zstrb.rf_we", 128'(debug_wb_rf_we), 128'(0));

        // Reset with two queued
        drive(1, mk(4'hF, 5'd22, 32'h22, 32'h500), 0, 0, 0);
        drive(1, mk(4'hF, 5'd23, 32'h23, 32'h504), 0, 0, 0);
        drive(0, '0, 1, 0, 1);
        drive(0, '0, 1, 0, 0);
        @(negedge clk);
        check_reset_outputs("midrst");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rb = {$urandom, $urandom, $urandom};
            drive(($urandom_range(0, 99) < 60), rb, ($urandom_range(0, 99) < 65),
                  ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 2));
        end
        drive(0, '0, 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_retire_stage.md
Name: wb_retire_stage

Overview:
- Parametrised successor to the single-register writeback stage.
- Sits between the memory-access stage and the register-file write port. Holds up to DEPTH completed instructions in an in-order retire queue.
- Retires one instruction per cycle when the shared write port grants (rf_ready). Drives byte-strobed register writes, per-entry hazard destinations for decode, and the trace debug interface.
- Adds backpressure tolerance and a cancel (flush) path.

Parameters:
- DATA_W, 32, result/write-data width; must be a multiple of 8.
- ADDR_W, 5, register address width.
- PC_W, 32, pc width.
- DEPTH, 2, retire-queue entries; power of 2, >=1.
- WSTRB_W, DATA_W/8, derived byte-strobe width; not overridable.
- BUS_W, WSTRB_W+ADDR_W+DATA_W+PC_W, derived input bus width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ma_validout  in  1  MA stage holds a valid instruction.
- ma_to_wb_bus  in  BUS_W  {wstrb[BUS_W-1 -: WSTRB_W], dest, result, pc[PC_W-1:0]}.
- wb_allowin  out  1  queue can accept this cycle.
- rf_ready  in  1  register-file write port granted this cycle.
- wb_cancel  in  1  discard all queued, unretired entries.
- wb_validout  out  1  an instruction retires this cycle.
- wb_regfile_bus  out  WSTRB_W+ADDR_W+DATA_W  {rf_we[WSTRB_W], rf_waddr, rf_wdata}.
- wb_dest_vec  out  DEPTH*ADDR_W  entry i's dest at [i*ADDR_W +: ADDR_W]; 0 when slot invalid.
- debug_wb_pc  out  PC_W  pc of the head entry.
- debug_wb_rf_we  out  WSTRB_W  equals rf_we.
- debug_wb_rf_wnum  out  ADDR_W  dest of the head entry.
- debug_wb_rf_wdata  out  DATA_W  result of the head entry.

Behaviour:
- One clock, clk.
- rst is synchronous and active-high. It clears head_ptr, tail_ptr, count and all slot valid bits.
- After reset:
  - wb_allowin=1
  - wb_validout=0
  - rf_we=0
  - wb_dest_vec=0
  - debug_wb_rf_we=0
  - Slot payload registers reset to 0, so debug_wb_pc/wnum/wdata read 0.
- Storage:
  - Circular buffer of DEPTH slots, each {valid, wstrb, dest, result, pc}.
  - head_ptr and tail_ptr are log2(DEPTH) bits (0 bits when DEPTH=1) and wrap naturally.
  - count is $clog2(DEPTH+1) bits, range 0..DEPTH.
- Combinational control signals:
  - head_v = slot[head_ptr].valid
  - pop = head_v & rf_ready & ~wb_cancel
  - push = ma_validout & wb_allowin & ~wb_cancel
  - wb_allowin = (count != DEPTH) | pop
- Push/pop rules:
  - Push and pop may occur in the same cycle, including when the queue is full. In that case count is unchanged and both pointers advance.
  - Push writes the tail slot and sets its valid bit. Pop clears the head valid bit.
- Latency:
  - Minimum 1 cycle from acceptance to retire; there is no same-cycle bypass from ma_to_wb_bus.
  - With rf_ready held at 1, steady-state throughput is 1 per cycle.
- Retire outputs are combinational from the head slot:
  - wb_validout = pop.
  - rf_we = pop ? head.wstrb : 0.
  - rf_waddr = head.dest.
  - rf_wdata = head.result.
- An entry whose wstrb is 0 still occupies a slot and retires (trace visibility) with rf_we=0.
- Debug:
  - debug_wb_rf_we = rf_we.
  - debug pc/wnum/wdata always show the head slot. Their contents are meaningful only when wb_validout=1.
- Hazard vector:
  - Each field of wb_dest_vec is indexed by physical slot, not by age, and is gated by that slot's valid bit.
  - A slot retiring this cycle still reports its dest this cycle.
- wb_cancel, when asserted in a cycle:
  - No pop (rf_we=0, wb_validout=0) and no push.
  - At the next edge, all valid bits clear, count=0 and head_ptr=tail_ptr=0.
  - wb_allowin is still computed normally. The MA stage is responsible for dropping its own instruction.
- Simultaneous events:
  - rst dominates wb_cancel.
  - wb_cancel dominates push and pop.
- Hold and reset mid-operation:
  - rf_ready=0 with the queue non-empty holds the head and all outputs stable.
  - rst mid-operation discards all entries with no write.
- DEPTH=1 with rf_ready tied to 1 behaves as the original single-register stage, plus the strobes.

Test Plan:
- Reset, then send 3 back-to-back entries with rf_ready=1 and DEPTH=2: {wstrb=F, dest=3, result=0x11, pc=0x1c000000}, then dest=4 and dest=5 -> retires on cycles 1, 2, 3 after each accept, in order. rf_we=F; wb_allowin stays 1.
- rf_ready=0; push dest=6 then dest=7 -> count=2 and wb_allowin=0. A third ma_validout is not accepted. wb_dest_vec shows {7,6}. Raise rf_ready -> dest=6 retires, and the third entry is accepted in the same cycle.
- Queue full with rf_ready=1 and ma_validout=1 held for 8 cycles -> push+pop every cycle, count stays 2, pointers wrap, pc order preserved.
- 2 entries queued, rf_ready=1, wb_cancel pulse -> no write in the cancel cycle. The next cycle has wb_dest_vec=0, wb_allowin=1 and no retire.
- Entry with wstrb=0x3, result=0xAABBCCDD, dest=9 -> rf_we=0x3 and debug_wb_rf_we=0x3. An entry with wstrb=0 retires with wb_validout=1 and rf_we=0.
- rst asserted with 2 entries queued -> the next cycle has every output at its reset value and no rf_we pulse ever occurs for the discarded entries.
